// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// FSM state encoding and counter sizing used by the top level.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// master drives operands and consumes results; slave is the adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder composed of two half adders and an OR of their carries.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ha0_sum;
  logic ha0_cout;
  logic ha1_cout;

  half_adder u_ha0 (
    .a   (a),
    .b   (b),
    .sum (ha0_sum),
    .cout(ha0_cout)
  );

  half_adder u_ha1 (
    .a   (ha0_sum),
    .b   (ci),
    .sum (s),
    .cout(ha1_cout)
  );

  assign co = ha0_cout | ha1_cout;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: sum and carry of two input bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, with valid/ready
// handshakes on operands and result.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sa_state_t        state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_sh_next;

  full_adder u_fa (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .ci(carry),
    .s (fa_s),
    .co(fa_co)
  );

  assign sum_sh_next = {fa_s, sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.cin;
            cnt    <= '0;
            sum_sh <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_sh_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          if (cnt == CntLast) begin
            // Publish directly from the adder so the result lands with DONE.
            sum_q  <= sum_sh_next;
            cout_q <= fa_co;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder with hand-computed results.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid after an accept edge; returns edges taken.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
    int lat;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_sum_hold"}, 32'(bus.sum), 32'(exp_sum));
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    run_op("5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure: result held for 5 cycles in DONE.
    bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_sum", 32'(bus.sum), 32'h46);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release", 32'(bus.out_valid), 32'd0);

    // Reset on the 4th RUN edge of AA+55.
    bus.a = 8'hAA; bus.b = 8'h55; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    run_op("01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // in_valid held with fresh operands during RUN must not disturb the result.
    bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.a = 8'h70; bus.b = 8'h07;
    wait_done(lat);
    check("ovl_latency", 32'(lat), 32'd8);
    check("ovl_sum", 32'(bus.sum), 32'h10);
    check("ovl_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("ovl_hs_idle", 32'(bus.in_ready), 32'd1);
    check("ovl_hs_busy", 32'(bus.busy), 32'd0);
    check("ovl_hs_sum", 32'(bus.sum), 32'h10);
    tick();
    bus.in_valid = 1'b0;
    check("ovl_second_busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    check("ovl_second_latency", 32'(lat), 32'd8);
    check("ovl_second_sum", 32'(bus.sum), 32'h77);
    check("ovl_second_cout", 32'(bus.cout), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
